// File: rtl/ram_reader_pkg.sv
// ram_reader_pkg: shared widths and FSM encoding for the RAM streaming reader.
package ram_reader_pkg;
   localparam int ADDR_W_DEF = 9;
   localparam int DATA_W_DEF = 16;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_e;
endpackage

// File: rtl/ram_reader_stream_reg.sv
// ram_reader_stream_reg: one-entry ready/valid output register with free-slot flag.
module ram_reader_stream_reg #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_i,
   input  logic [DATA_W-1:0] data_d,
   input  logic              ready_i,
   output logic [DATA_W-1:0] data_q,
   output logic              valid_q,
   output logic              free_o
);
   // Slot may be refilled in the same cycle the held word is handed off.
   assign free_o = !valid_q || ready_i;
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else if (load_i) begin
         data_q  <= data_d;
         valid_q <= 1'b1;
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end
endmodule

// File: rtl/ram_reader.sv
// ram_reader: streams a contiguous, address-wrapping range of RAM words onto a ready/valid output.
module ram_reader
   import ram_reader_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W:0]   length,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] ram_address,
   input  logic [DATA_W-1:0] ram_out,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready
);
   state_e            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W:0]   remaining_q;
   logic              done_q;
   logic              slot_free;
   logic              capture;
   assign capture     = (state_q == RUN) && slot_free;
   assign busy        = state_q != IDLE;
   assign done        = done_q;
   assign ram_address = addr_q;
   ram_reader_stream_reg #(.DATA_W(DATA_W)) u_out (
      .clk     (clk),
      .reset   (reset),
      .load_i  (capture),
      .data_d  (ram_out),
      .ready_i (m_ready),
      .data_q  (m_data),
      .valid_q (m_valid),
      .free_o  (slot_free)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               if (length != '0) begin
                  addr_q      <= base;
                  remaining_q <= length;
                  state_q     <= RUN;
               end else begin
                  done_q <= 1'b1;
               end
            end
            RUN: if (slot_free) begin
               addr_q      <= addr_q + 1'b1;
               remaining_q <= remaining_q - 1'b1;
               if (remaining_q == (ADDR_W+1)'(1)) state_q <= FLUSH;
            end
            FLUSH: if (m_valid && m_ready) begin
               state_q <= IDLE;
               done_q  <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ram_reader.sv
// tb_ram_reader: directed checks of ram_reader against a RAM preloaded with a^16'hA5A5.
module tb_ram_reader;
   localparam int AW = 9;
   localparam int DW = 16;
   logic          clk = 1'b0;
   logic          reset, start, m_ready;
   logic [AW-1:0] base;
   logic [AW:0]   length;
   logic          busy, done, m_valid;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_out, m_data;
   int checks = 0;
   int failures = 0;
   always #5 clk = ~clk;
   assign ram_out = DW'(ram_address) ^ 16'hA5A5;
   ram_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .base        (base),
      .length      (length),
      .busy        (busy),
      .done        (done),
      .ram_address (ram_address),
      .ram_out     (ram_out),
      .m_data      (m_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready)
   );
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic launch(input logic [AW-1:0] b, input logic [AW:0] l);
      start = 1'b1; base = b; length = l;
      tick();
      start = 1'b0;
   endtask
   task automatic test_reset();
      reset = 1'b1; start = 1'b0; m_ready = 1'b0; base = '0; length = '0;
      tick(); tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
      checks++; if (m_data !== 16'h0) begin failures++; $display("FAIL reset_data got=%h exp=0000", m_data); end
      checks++; if (ram_address !== 9'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", ram_address); end
      reset = 1'b0;
      tick();
   endtask
   task automatic test_basic();
      logic [DW-1:0] exp_w [4] = '{16'hA5A5, 16'hA5A4, 16'hA5A7, 16'hA5A6};
      m_ready = 1'b1;
      launch(9'd0, 10'd4);
      checks++; if (busy !== 1'b1 || ram_address !== 9'd0 || m_valid !== 1'b0) begin failures++; $display("FAIL basic_k1 got busy=%b addr=%0d valid=%b exp 1/0/0", busy, ram_address, m_valid); end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (m_valid !== 1'b1 || m_data !== exp_w[i] || done !== 1'b0) begin failures++; $display("FAIL basic_word%0d got valid=%b data=%h done=%b exp 1/%h/0", i, m_valid, m_data, done, exp_w[i]); end
      end
      tick();
      checks++; if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin failures++; $display("FAIL basic_done got done=%b busy=%b valid=%b exp 1/0/0", done, busy, m_valid); end
      tick();
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
   endtask
   task automatic test_wrap();
      logic [DW-1:0] exp_w [4] = '{16'hA45B, 16'hA45A, 16'hA5A5, 16'hA5A4};
      int n_done = 0;
      m_ready = 1'b1;
      launch(9'd510, 10'd4);
      checks++; if (ram_address !== 9'd510) begin failures++; $display("FAIL wrap_addr got=%0d exp=510", ram_address); end
      for (int i = 0; i < 4; i++) begin
         tick();
         if (done) n_done++;
         checks++; if (m_valid !== 1'b1 || m_data !== exp_w[i]) begin failures++; $display("FAIL wrap_word%0d got valid=%b data=%h exp 1/%h", i, m_valid, m_data, exp_w[i]); end
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         if (done) n_done++;
      end
      checks++; if (n_done != 1) begin failures++; $display("FAIL wrap_done_count got=%0d exp=1", n_done); end
      checks++; if (busy !== 1'b0 || ram_address !== 9'd2) begin failures++; $display("FAIL wrap_after got busy=%b addr=%0d exp 0/2", busy, ram_address); end
   endtask
   task automatic test_zero_len();
      launch(9'd100, 10'd0);
      checks++; if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0 || ram_address !== 9'd2) begin failures++; $display("FAIL zero_len got done=%b busy=%b valid=%b addr=%0d exp 1/0/0/2", done, busy, m_valid, ram_address); end
      tick();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL zero_len_after got done=%b busy=%b exp 0/0", done, busy); end
   endtask
   task automatic test_full_random();
      int idx = 0, stalls = 0, cyc = 1, errs = 0;
      logic prev_stall = 1'b0;
      logic [DW-1:0] prev_data = '0;
      m_ready = 1'b0;
      launch(9'd0, 10'd512);
      while (!done && cyc < 3000) begin
         m_ready = 1'($urandom_range(0, 1));
         if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data)) begin
            errs++;
            if (errs < 5) $display("FAIL full_stall_stable got valid=%b data=%h exp 1/%h", m_valid, m_data, prev_data);
         end
         if (m_valid && m_ready) begin
            if (m_data !== (DW'(idx) ^ 16'hA5A5)) begin
               errs++;
               if (errs < 5) $display("FAIL full_word%0d got=%h exp=%h", idx, m_data, DW'(idx) ^ 16'hA5A5);
            end
            idx++;
         end
         if (m_valid && !m_ready) stalls++;
         prev_stall = m_valid && !m_ready;
         prev_data = m_data;
         tick();
         cyc++;
      end
      checks++; if (errs != 0) begin failures++; $display("FAIL full_stream errors got=%0d exp=0", errs); end
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL full_timeout got done=%b exp=1", done); end
      checks++; if (idx != 512) begin failures++; $display("FAIL full_count got=%0d exp=512", idx); end
      checks++; if (cyc != 514 + stalls) begin failures++; $display("FAIL full_cycles got=%0d exp=%0d", cyc, 514 + stalls); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_busy_at_done got=%b exp=0", busy); end
      m_ready = 1'b1;
      tick();
   endtask
   task automatic test_ignore_start();
      int idx = 0, cyc = 1, errs = 0;
      m_ready = 1'b1;
      launch(9'd20, 10'd6);
      while (!done && cyc < 40) begin
         start = (cyc == 3);
         if (cyc == 3) begin base = 9'd300; length = 10'd3; end
         if (m_valid) begin
            if (m_data !== (DW'(20 + idx) ^ 16'hA5A5)) begin
               errs++;
               $display("FAIL ignore_word%0d got=%h exp=%h", idx, m_data, DW'(20 + idx) ^ 16'hA5A5);
            end
            idx++;
         end
         tick();
         cyc++;
      end
      start = 1'b0;
      checks++; if (errs != 0) begin failures++; $display("FAIL ignore_stream errors got=%0d exp=0", errs); end
      checks++; if (idx != 6 || cyc != 8) begin failures++; $display("FAIL ignore_timing got words=%0d cyc=%0d exp 6/8", idx, cyc); end
      checks++; if (ram_address !== 9'd26) begin failures++; $display("FAIL ignore_addr got=%0d exp=26", ram_address); end
      tick();
      checks++; if (m_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL ignore_idle got valid=%b busy=%b exp 0/0", m_valid, busy); end
   endtask
   task automatic test_reset_mid();
      int n_done = 0;
      m_ready = 1'b1;
      launch(9'd40, 10'd8);
      tick(); tick(); tick();
      checks++; if (m_data !== (16'd42 ^ 16'hA5A5)) begin failures++; $display("FAIL rstmid_word2 got=%h exp=%h", m_data, 16'd42 ^ 16'hA5A5); end
      reset = 1'b1;
      tick();
      checks++; if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rstmid_abort got valid=%b busy=%b done=%b exp 0/0/0", m_valid, busy, done); end
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done || m_valid) n_done++;
      end
      checks++; if (n_done != 0) begin failures++; $display("FAIL rstmid_quiet got=%0d exp=0", n_done); end
      launch(9'd7, 10'd2);
      tick();
      checks++; if (m_valid !== 1'b1 || m_data !== 16'hA5A2) begin failures++; $display("FAIL rstmid_fresh0 got valid=%b data=%h exp 1/a5a2", m_valid, m_data); end
      tick();
      checks++; if (m_valid !== 1'b1 || m_data !== 16'hA5AD) begin failures++; $display("FAIL rstmid_fresh1 got valid=%b data=%h exp 1/a5ad", m_valid, m_data); end
      tick();
      checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_fresh_done got done=%b busy=%b exp 1/0", done, busy); end
   endtask
   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_zero_len();
      test_full_random();
      test_ignore_start();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
